wshb_arbiter: RTL and testbench
===============================

// Module: wshb_arbiter
// PURPOSE
//  Two-master round-robin arbiter for the shared Wishbone SDRAM port.
//  Master 0 is the VGA framebuffer reader, which keeps cyc/stb high permanently.
//  Master 1 is any other client, e.g. a frame writer or pattern generator.
//  A per-master quantum of acks bounds bus hold time, so the permanent-cyc reader cannot starve master 1.
//  Sits between the clients and the SDRAM controller's single wshb_if slave port.
// PARAMETERS
//  QUANTUM_0  64  max acks granted to master 0 before yielding, if master 1 is requesting
//  QUANTUM_1  16  max acks granted to master 1 before yielding, if master 0 is requesting
//  (localparam CNT_W = $clog2(max(QUANTUM_0,QUANTUM_1)+1))
// PORTS
//  CLK       input   1        sole clock; all three wshb_if instances are clocked by CLK
//  rst       input   1        synchronous reset, active-high
//  wshb_s0   wshb_if.slave    port for master 0 (VGA reader)
//  wshb_s1   wshb_if.slave    port for master 1
//  wshb_m    wshb_if.master   to SDRAM controller
//  grant     output  2        one-hot current owner (00 = idle); debug/status
// BEHAVIOUR
//  - FSM states: ARB_IDLE, ARB_GNT0, ARB_GNT1. Registers: state, ack counter cnt, last_owner.
//  - Reset (sync): state=ARB_IDLE, cnt=0, last_owner=1 so master 0 wins the first arbitration.
//    Outputs follow on the next edge: wshb_m.cyc=stb=0, s0/s1 ack=err=rty=0, grant=00.
//    Reset mid-transfer drops the transaction; the bus shows cyc=0 from the following cycle.
//  - Arbitration requires cyc; stb is not required.
//  - ARB_IDLE:
//    - Only sN.cyc=1 -> ARB_GNTn.
//    - Both cyc=1 -> grant the master != last_owner.
//    - Neither -> stay.
//    - Entering a grant clears cnt and sets last_owner.
//    - One-cycle decision latency: request at edge k, wshb_m.cyc=1 after edge k+1.
//  - ARB_GNTn, output mux (combinational from state):
//    - wshb_m.{adr,dat_ms,we,sel,stb,cyc,cti,bte} = sN.*
//    - wshb_m.dat_sm is broadcast to both slaves.
//    - ack/err/rty go to sN only; the other master sees 0 and waits.
//  - ARB_GNTn transitions, checked in priority order:
//    1. sN.cyc=0 -> ARB_IDLE.
//    2. wshb_m.ack=1, cnt==QUANTUM_n-1 and the other master's cyc=1 -> ARB_IDLE (yield).
//       - Exception: sN.cti==3'b010 (incrementing burst in progress) forbids yielding.
//         The yield is deferred to the first ack with cti==3'b111 or cti==3'b000.
//    3. Otherwise stay. cnt increments on every ack and saturates at QUANTUM_n-1.
//  - Ownership changes only through ARB_IDLE, which guarantees one cycle of cyc=0.
//    The SDRAM controller sees a clean cycle boundary at every ownership change.
//  - Uncontested master: cnt saturates, no yield, ownership kept indefinitely.
//  - err and rty count as a transfer end like ack, for quantum and burst purposes.
//  - wshb_m.ack when state=ARB_IDLE (protocol violation): ignored, not forwarded.
//  - Simultaneous yield and sN.cyc drop: rule 1 wins; the result is the same state.
// STRUCTURE
//  - Package wshb_arb_pkg:
//    - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GNT0, ARB_GNT1}
//    - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111
//  - Sub-module wshb_arb_mux: purely combinational master-select, driven by state.
//  - The FSM and counter stay in wshb_arbiter.
// TESTING
//  1. Reset then s0.cyc=stb=1 only, slave acks every cycle -> grant=01 two edges after reset release.
//     s0 receives every ack; never yields across 1000 acks.
//  2. s0 and s1 both cyc=1 from reset -> grant sequence 01 (64 acks), 00 (1 cycle), 10 (16 acks), 00, 01...
//     s1 never sees an ack while grant=01.
//  3. s1 owns the bus in an incrementing burst (cti=010) at ack 15 while s0 requests -> no yield.
//     Yield happens on the ack with cti=111 (ack 20); idle cycle; then grant=01.
//  4. s0 drops cyc after 5 acks, with s1 idle -> ARB_IDLE next edge, wshb_m.cyc=0.
//     s1 then requests alone -> grant=10 with cnt=0.
//  5. rst pulsed during a transfer mid-way through the s1 quantum -> all acks 0 and wshb_m.cyc=0 after the edge.
//     With both requesting after reset, master 0 is granted first.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
//  arb_state_t : arbiter FSM encoding (also used to drive the master-select mux)
//  CTI_*       : Wishbone cycle-type identifiers the arbiter cares about
//  yield_ok()  : true when the owner's current transfer may end its tenure
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Ownership may only be taken away on a classic cycle or on the last beat of
  // a burst; mid-burst the transfer is allowed to run past its quantum.
  function automatic logic yield_ok(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle used for both client ports and the SDRAM-side port.
//  master modport : drives adr/dat_ms/we/sel/stb/cyc/cti/bte, receives dat_sm/ack/err/rty
//  slave  modport : the mirror image
// All instances share the arbiter clock; the bundle itself carries no clock.
interface wshb_if #(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32
);
  localparam int SEL_W = DAT_W / 8;

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_ms;
  logic [DAT_W-1:0] dat_sm;
  logic             we;
  logic [SEL_W-1:0] sel;
  logic             stb;
  logic             cyc;
  logic             ack;
  logic             err;
  logic             rty;
  logic [2:0]       cti;
  logic [1:0]       bte;

  modport master (
    output adr, dat_ms, we, sel, stb, cyc, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  adr, dat_ms, we, sel, stb, cyc, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_arb_mux.sv
// Purely combinational master-select for the arbiter.
//  state : current arbiter state; selects which client reaches the SDRAM port
//  s0/s1 : client ports (slave side)
//  m     : SDRAM controller port (master side)
// Read data is broadcast; responses (ack/err/rty) reach the owner only.
// In ARB_IDLE the SDRAM port sees cyc=stb=0 and any stray response is dropped.
module wshb_arb_mux
  import wshb_arb_pkg::*;
(
  input  arb_state_t    state,
  wshb_if.slave         s0,
  wshb_if.slave         s1,
  wshb_if.master        m
);

  always_comb begin
    m.adr    = '0;
    m.dat_ms = '0;
    m.we     = 1'b0;
    m.sel    = '0;
    m.stb    = 1'b0;
    m.cyc    = 1'b0;
    m.cti    = CTI_CLASSIC;
    m.bte    = 2'b00;
    s0.ack   = 1'b0;
    s0.err   = 1'b0;
    s0.rty   = 1'b0;
    s1.ack   = 1'b0;
    s1.err   = 1'b0;
    s1.rty   = 1'b0;
    s0.dat_sm = m.dat_sm;
    s1.dat_sm = m.dat_sm;

    case (state)
      ARB_GNT0: begin
        m.adr    = s0.adr;
        m.dat_ms = s0.dat_ms;
        m.we     = s0.we;
        m.sel    = s0.sel;
        m.stb    = s0.stb;
        m.cyc    = s0.cyc;
        m.cti    = s0.cti;
        m.bte    = s0.bte;
        s0.ack   = m.ack;
        s0.err   = m.err;
        s0.rty   = m.rty;
      end
      ARB_GNT1: begin
        m.adr    = s1.adr;
        m.dat_ms = s1.dat_ms;
        m.we     = s1.we;
        m.sel    = s1.sel;
        m.stb    = s1.stb;
        m.cyc    = s1.cyc;
        m.cti    = s1.cti;
        m.bte    = s1.bte;
        s1.ack   = m.ack;
        s1.err   = m.err;
        s1.rty   = m.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller's Wishbone port.
//  CLK     : sole clock
//  rst     : synchronous, active-high reset
//  wshb_s0 : master 0 (VGA framebuffer reader, holds cyc permanently)
//  wshb_s1 : master 1 (any other client)
//  wshb_m  : to the SDRAM controller
//  grant   : one-hot current owner, 00 when idle (debug/status)
// Handshake: a client requests by raising cyc (stb is not needed to win).
// The owner keeps the bus until it drops cyc, or until it has received its
// quantum of transfer ends (ack/err/rty) while the other client is waiting.
// Every ownership change passes through ARB_IDLE, so the SDRAM controller
// always sees at least one cycle of cyc=0 between owners.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int QUANTUM_0 = 64,
  parameter int QUANTUM_1 = 16
) (
  input  logic       CLK,
  input  logic       rst,
  wshb_if.slave      wshb_s0,
  wshb_if.slave      wshb_s1,
  wshb_if.master     wshb_m,
  output logic [1:0] grant
);

  localparam int CNT_W = $clog2((QUANTUM_0 > QUANTUM_1 ? QUANTUM_0 : QUANTUM_1) + 1);
  localparam logic [CNT_W-1:0] Q0_LAST = CNT_W'(QUANTUM_0 - 1);
  localparam logic [CNT_W-1:0] Q1_LAST = CNT_W'(QUANTUM_1 - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // 1 when master 1 held the bus most recently; reset to 1 so master 0 wins first.
  logic             last_owner_q, last_owner_d;
  logic             xfer_end;

  assign xfer_end = wshb_m.ack | wshb_m.err | wshb_m.rty;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;

    case (state_q)
      ARB_IDLE: begin
        // Responses arriving here are protocol violations and are ignored.
        if (wshb_s0.cyc && wshb_s1.cyc) begin
          state_d = last_owner_q ? ARB_GNT0 : ARB_GNT1;
        end else if (wshb_s0.cyc) begin
          state_d = ARB_GNT0;
        end else if (wshb_s1.cyc) begin
          state_d = ARB_GNT1;
        end
        if (state_d != ARB_IDLE) begin
          cnt_d        = '0;
          last_owner_d = (state_d == ARB_GNT1);
        end
      end

      ARB_GNT0: begin
        if (!wshb_s0.cyc) begin
          state_d = ARB_IDLE;
        end else if (xfer_end) begin
          if (cnt_q == Q0_LAST && wshb_s1.cyc && yield_ok(wshb_s0.cti)) begin
            state_d = ARB_IDLE;
          end else if (cnt_q != Q0_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ARB_GNT1: begin
        if (!wshb_s1.cyc) begin
          state_d = ARB_IDLE;
        end else if (xfer_end) begin
          if (cnt_q == Q1_LAST && wshb_s0.cyc && yield_ok(wshb_s1.cti)) begin
            state_d = ARB_IDLE;
          end else if (cnt_q != Q1_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  assign grant = {state_q == ARB_GNT1, state_q == ARB_GNT0};

  wshb_arb_mux u_mux (
    .state (state_q),
    .s0    (wshb_s0),
    .s1    (wshb_s1),
    .m     (wshb_m)
  );

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter. Stimulus pushes the expected sequence of ownership
// segments {grant, transfer ends, cycles}; a negedge monitor closes a segment
// whenever grant changes and compares it, and checks response routing on
// every transfer end against the segment it expects to be in.
module tb_wshb_arbiter;
  import wshb_arb_pkg::*;

  localparam int SEG_W = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  grant;
  logic        resp_err = 1'b0;
  logic [31:0] slv_dat = 32'h5A5A_0001;
  logic        mon_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [SEG_W-1:0] exp_q[$];

  wshb_if s0_if ();
  wshb_if s1_if ();
  wshb_if m_if ();

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  wshb_arbiter #(.QUANTUM_0(64), .QUANTUM_1(16)) dut (
    .CLK     (clk),
    .rst     (rst),
    .wshb_s0 (s0_if),
    .wshb_s1 (s1_if),
    .wshb_m  (m_if),
    .grant   (grant)
  );

  // SDRAM-side model: single-cycle response to every strobe.
  assign m_if.ack    = m_if.cyc & m_if.stb & ~resp_err;
  assign m_if.err    = m_if.cyc & m_if.stb & resp_err;
  assign m_if.rty    = 1'b0;
  assign m_if.dat_sm = slv_dat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [SEG_W-1:0] seg(input logic [1:0] g, input int acks, input int cycles);
    logic [15:0] a;
    logic [15:0] c;
    a = acks[15:0];
    c = cycles[15:0];
    return {g, a, c};
  endfunction

  task automatic drive(input int m, input logic cyc, input logic [2:0] cti);
    if (m == 0) begin
      s0_if.cyc = cyc; s0_if.stb = cyc; s0_if.cti = cti;
    end else begin
      s1_if.cyc = cyc; s1_if.stb = cyc; s1_if.cti = cti;
    end
  endtask

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for n transfer ends delivered to master m.
  task automatic run_acks(input int m, input int n);
    int got;
    int budget;
    got = 0;
    budget = 0;
    while (got < n && budget < n * 4 + 20) begin
      @(negedge clk);
      budget++;
      if (m == 0 ? (s0_if.ack | s0_if.err) : (s1_if.ack | s1_if.err)) got++;
    end
    check($sformatf("run_acks_m%0d", m), 64'(got), 64'(n));
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_mcyc", 64'(m_if.cyc), 64'd0);
    check("rst_acks", 64'({s1_if.ack, s0_if.ack, s1_if.err, s0_if.err}), 64'd0);
    at_edge();
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic finish_test(input string name);
    repeat (4) @(negedge clk);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    at_edge();
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [1:0] seg_grant = 2'b00;
  int         seg_acks = 0;
  int         seg_cycles = 0;
  logic [1:0] exp_g;

  always @(negedge clk) begin
    if (!mon_en) begin
      seg_grant  = 2'b00;
      seg_acks   = 0;
      seg_cycles = 0;
    end else begin
      if (grant !== seg_grant) begin
        check("seg_avail", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0)
          check("segment", 64'(seg(seg_grant, seg_acks, seg_cycles)), 64'(exp_q.pop_front()));
        seg_grant  = grant;
        seg_acks   = 0;
        seg_cycles = 0;
      end
      seg_cycles++;
      if (m_if.ack | m_if.err) begin
        seg_acks++;
        exp_g = (exp_q.size() > 0) ? exp_q[0][SEG_W-1 -: 2] : 2'b11;
        check("ack_route", 64'({s1_if.ack | s1_if.err, s0_if.ack | s0_if.err}), 64'(exp_g));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    s0_if.adr = 32'h0000_0100; s0_if.dat_ms = 32'h0;         s0_if.we = 1'b0;
    s0_if.sel = 4'hF;          s0_if.bte = 2'b00;
    s1_if.adr = 32'h1000_0040; s1_if.dat_ms = 32'hDEAD_BEEF; s1_if.we = 1'b1;
    s1_if.sel = 4'hF;          s1_if.bte = 2'b00;
    drive(0, 1'b0, CTI_CLASSIC);
    drive(1, 1'b0, CTI_CLASSIC);

    // Test 1: master 0 alone never yields.
    drive(0, 1'b1, CTI_CLASSIC);
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b01, 1000, 1001));
    do_reset();
    run_acks(0, 1000);
    at_edge();
    drive(0, 1'b0, CTI_CLASSIC);
    finish_test("t1");

    // Test 2: both request continuously; quanta alternate with idle gaps.
    drive(0, 1'b1, CTI_CLASSIC);
    drive(1, 1'b1, CTI_CLASSIC);
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b01, 64, 64));
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b10, 16, 16));
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b01, 64, 64));
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b10, 5, 6));
    do_reset();
    run_acks(0, 64);
    run_acks(1, 16);
    run_acks(0, 64);
    run_acks(1, 5);
    at_edge();
    drive(0, 1'b0, CTI_CLASSIC);
    drive(1, 1'b0, CTI_CLASSIC);
    finish_test("t2");

    // Test 3: master 1 in an incrementing burst overruns its quantum.
    drive(1, 1'b1, CTI_INCR);
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b10, 20, 20));
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b01, 3, 4));
    do_reset();
    run_acks(1, 3);
    check("mux_adr", 64'(m_if.adr), 64'h1000_0040);
    check("mux_we", 64'(m_if.we), 64'd1);
    check("mux_dat_ms", 64'(m_if.dat_ms), 64'hDEAD_BEEF);
    check("mux_cti", 64'(m_if.cti), 64'(CTI_INCR));
    check("dat_sm_bcast", 64'({s0_if.dat_sm, s1_if.dat_sm}), {slv_dat, slv_dat});
    at_edge();
    drive(0, 1'b1, CTI_CLASSIC);
    run_acks(1, 16);
    at_edge();
    s1_if.cti = CTI_EOB;
    run_acks(1, 1);
    at_edge();
    drive(1, 1'b0, CTI_CLASSIC);
    run_acks(0, 3);
    at_edge();
    drive(0, 1'b0, CTI_CLASSIC);
    finish_test("t3");

    // Test 4: master 0 drops cyc; master 1 starts with a fresh counter (err counts).
    drive(0, 1'b1, CTI_CLASSIC);
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b01, 5, 6));
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b10, 16, 16));
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b01, 2, 3));
    do_reset();
    run_acks(0, 5);
    at_edge();
    drive(0, 1'b0, CTI_CLASSIC);
    @(negedge clk);
    check("drop_mcyc", 64'(m_if.cyc), 64'd0);
    at_edge();
    drive(1, 1'b1, CTI_CLASSIC);
    resp_err = 1'b1;
    @(negedge clk);
    check("drop_idle", 64'(grant), 64'd0);
    run_acks(1, 5);
    at_edge();
    resp_err = 1'b0;
    drive(0, 1'b1, CTI_CLASSIC);
    run_acks(1, 11);
    at_edge();
    drive(1, 1'b0, CTI_CLASSIC);
    run_acks(0, 2);
    at_edge();
    drive(0, 1'b0, CTI_CLASSIC);
    finish_test("t4");

    // Test 5: reset pulse mid-quantum of master 1.
    drive(1, 1'b1, CTI_CLASSIC);
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b10, 9, 9));
    exp_q.push_back(seg(2'b00, 0, 1));
    exp_q.push_back(seg(2'b01, 3, 4));
    do_reset();
    run_acks(1, 8);
    at_edge();
    rst = 1'b1;
    drive(0, 1'b1, CTI_CLASSIC);
    at_edge();
    rst = 1'b0;
    @(negedge clk);
    check("rst5_grant", 64'(grant), 64'd0);
    check("rst5_mcyc", 64'(m_if.cyc), 64'd0);
    check("rst5_acks", 64'({s1_if.ack, s0_if.ack}), 64'd0);
    run_acks(0, 3);
    at_edge();
    drive(0, 1'b0, CTI_CLASSIC);
    drive(1, 1'b0, CTI_CLASSIC);
    finish_test("t5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
